multi_ch_delay_buffer: RTL

- N_CH-channel circular sample history for delay-and-sum beamforming. It sits between the per-mic recorders and the beamform accumulator.
- Every write strobe stores one sample per channel.
- Each read request returns two samples for one channel: the sample at delay d, and the sample at delay d+TAP_L.
- Single clock domain. Sample-rate strobes are pre-synchronised into i_clk by the recorders.

---
 rtl/dcl_audio_pkg.sv | 29 ++
 rtl/delay_ring_ch.sv | 40 ++++
 rtl/multi_ch_delay_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dcl_audio_pkg.sv
// Shared types and helpers for the multi-channel audio delay buffer.
// Sample type, fill-state encoding and circular index arithmetic.
package dcl_audio_pkg;

    localparam int DATA_W = 24;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILLING,
        S_FULL
    } state_t;

    // (a - b) mod depth, valid while b <= a + depth
    function automatic int mod_sub(
        input int a,
        input int b,
        input int depth
    );
        int r;
        r = a - b;
        if (r < 0) begin
            r = r + depth;
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_ring_ch.sv
// Single-channel sample ring with two registered read ports.
// The read registers reset to zero; the storage itself does not.
module delay_ring_ch #(
    parameter int DATA_W = dcl_audio_pkg::DATA_W,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    input  logic [AW-1:0]            rd_addr_l,
    output logic signed [DATA_W-1:0] rd_data,
    output logic signed [DATA_W-1:0] rd_data_l
);
    import dcl_audio_pkg::*;

    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads see pre-write contents when they hit the slot being written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            rd_data_l <= '0;
        end else if (rd_en) begin
            rd_data   <= mem[rd_addr];
            rd_data_l <= mem[rd_addr_l];
        end
    end

endmodule

// File: rtl/multi_ch_delay_buffer.sv
// N-channel circular sample history feeding the beamform accumulator.
// Each read returns taps at delay d and d+TAP_L for one channel.
module multi_ch_delay_buffer #(
    parameter int DATA_W = dcl_audio_pkg::DATA_W,
    parameter int DEPTH  = 64,
    parameter int N_CH   = 4,
    parameter int TAP_L  = 30,
    parameter int DLY_W  = $clog2(DEPTH),
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_wr_valid,
    input  logic [N_CH*DATA_W-1:0]   i_wr_data,
    input  logic                     i_rd_valid,
    input  logic [CH_W-1:0]          i_rd_ch,
    input  logic [DLY_W-1:0]         i_rd_delay,
    output logic                     o_rd_valid,
    output logic signed [DATA_W-1:0] o_rd_data,
    output logic signed [DATA_W-1:0] o_rd_data_l,
    output logic                     o_rd_err,
    output logic [DLY_W:0]           o_fill,
    output logic                     o_full
);
    import dcl_audio_pkg::*;

    localparam int AW = DLY_W + 2;

    state_t               state;
    logic [DLY_W-1:0]     wr_ptr;
    logic [DLY_W:0]       fill;
    logic                 wr_en;

    logic [DLY_W-1:0]     newest;
    logic [AW-1:0]        k_d;
    logic [AW-1:0]        k_l;
    logic [AW-1:0]        diff_d;
    logic [AW-1:0]        diff_l;
    logic [DLY_W-1:0]     addr_d;
    logic [DLY_W-1:0]     addr_l;
    logic                 req_err;
    logic [N_CH-1:0]      rd_sel;

    logic [CH_W-1:0]      ch_q;
    logic                 zero_q;

    logic signed [DATA_W-1:0] ring_d [N_CH];
    logic signed [DATA_W-1:0] ring_l [N_CH];

    assign wr_en  = i_wr_valid && !i_clear;
    assign o_fill = fill;
    assign o_full = (state == S_FULL);

    // Address and range check use the state before any same-cycle write
    always_comb begin
        newest = DLY_W'(mod_sub(int'(wr_ptr), 1, DEPTH));
        k_d    = {2'b00, i_rd_delay};
        k_l    = k_d + AW'(TAP_L);
        diff_d = {2'b00, newest} - k_d;
        diff_l = {2'b00, newest} - k_l;
        if (diff_d[AW-1]) begin
            diff_d = diff_d + AW'(DEPTH);
        end
        if (diff_l[AW-1]) begin
            diff_l = diff_l + AW'(DEPTH);
        end
        addr_d  = DLY_W'(diff_d);
        addr_l  = DLY_W'(diff_l);
        req_err = (int'(i_rd_delay) + TAP_L >= int'(fill))
               || (int'(i_rd_delay) >= DEPTH - TAP_L)
               || (int'(i_rd_ch) >= N_CH);
    end

    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            rd_sel[c] = i_rd_valid && !req_err && (int'(i_rd_ch) == c);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        delay_ring_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (DLY_W)
        ) u_ring (
            .clk       (i_clk),
            .rst       (i_rst),
            .wr_en     (wr_en),
            .wr_addr   (wr_ptr),
            .wr_data   (i_wr_data[c*DATA_W +: DATA_W]),
            .rd_en     (rd_sel[c]),
            .rd_addr   (addr_d),
            .rd_addr_l (addr_l),
            .rd_data   (ring_d[c]),
            .rd_data_l (ring_l[c])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_EMPTY;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (i_clear) begin
            state  <= S_EMPTY;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (i_wr_valid) begin
            wr_ptr <= (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            case (state)
                S_EMPTY, S_FILLING: begin
                    fill  <= fill + 1'b1;
                    state <= (int'(fill) == DEPTH - 1) ? S_FULL : S_FILLING;
                end
                S_FULL: begin
                    state <= S_FULL;
                end
                default: begin
                    state <= S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_valid <= 1'b0;
            o_rd_err   <= 1'b0;
            ch_q       <= '0;
            zero_q     <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_valid;
            o_rd_err   <= i_rd_valid && req_err;
            if (i_rd_valid) begin
                ch_q   <= i_rd_ch;
                zero_q <= req_err;
            end
        end
    end

    // Data holds between requests since ch_q/zero_q only move on a request
    always_comb begin
        o_rd_data   = '0;
        o_rd_data_l = '0;
        if (!zero_q) begin
            for (int c = 0; c < N_CH; c++) begin
                if (int'(ch_q) == c) begin
                    o_rd_data   = ring_d[c];
                    o_rd_data_l = ring_l[c];
                end
            end
        end
    end

endmodule
